// File: rtl/accel_spi_reader.sv
// ADXL345 SPI reader: configures the accelerometer, then periodically burst-reads X/Y and
// scales/saturates each axis to 8-bit signed. Define ACCEL_DEADZONE_EN to zero small readings.
module accel_spi_reader #(
   parameter int CLK_DIV       = 25,
   parameter int SAMPLE_PERIOD = 500000,
   parameter int SHIFT         = 2,
   parameter int DEADZONE      = 2
) (
   input  logic       clk,
   input  logic       arst_n,
   output logic       o_spi_sclk,
   output logic       o_spi_cs_n,
   output logic       o_spi_mosi,
   input  logic       i_spi_miso,
   output logic [7:0] o_accel_x,
   output logic [7:0] o_accel_y,
   output logic       o_valid,
   output logic       o_init_done
);

   typedef enum logic [2:0] {
      ST_PWRUP  = 3'd0,
      ST_CFG0   = 3'd1,
      ST_CFG1   = 3'd2,
      ST_WAIT   = 3'd3,
      ST_READ   = 3'd4,
      ST_UPDATE = 3'd5
   } state_t;

   localparam int WW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
   localparam int DW = $clog2(CLK_DIV);
   localparam logic [WW-1:0] WAIT_MAX = WW'(SAMPLE_PERIOD - 1);
   localparam logic [DW-1:0] DIV_MAX  = DW'(CLK_DIV - 1);

   // Half-period steps: 0 = CS lead-in, odd = SCLK low, even = SCLK high; beyond the last bit step CS is high.
   localparam logic [6:0] CFG_BITS_END  = 7'd32;
   localparam logic [6:0] READ_BITS_END = 7'd80;
   localparam logic [6:0] CFG0_LAST     = 7'd34;

`ifdef ACCEL_DEADZONE_EN
   localparam bit DZ_ENABLE = 1'b1;
`else
   localparam bit DZ_ENABLE = 1'b0;
`endif
   localparam int DZ_LIMIT = DZ_ENABLE ? DEADZONE : 0;

   function automatic logic [7:0] saturate(input logic [15:0] raw);
      logic signed [15:0] s;
      s = $signed(raw) >>> SHIFT;
      if (s > 16'sd127) begin
         return 8'h7F;
      end else if (s < -16'sd128) begin
         return 8'h80;
      end else begin
         return s[7:0];
      end
   endfunction

   function automatic logic [7:0] apply_deadzone(input logic [7:0] v);
      int sv;
      sv = int'($signed(v));
      if ((sv < DZ_LIMIT) && (sv > -DZ_LIMIT)) begin
         return 8'h00;
      end else begin
         return v;
      end
   endfunction

   state_t          state_r, state_s, after_s;
   logic [WW-1:0]   wait_cnt_r, wait_cnt_s;
   logic [DW-1:0]   div_r, div_s;
   logic [6:0]      step_r, step_s, last_step_s, bit_last_s;
   logic [31:0]     rx_r, rx_s;
   logic [39:0]     tx_word_s;
   logic [5:0]      bit_idx_s;
   logic            miso_r;
   logic            sclk_r, sclk_s, cs_n_r, cs_n_s, mosi_r, mosi_s;
   logic            half_done_s, xfer_s, cs_low_s;
   logic [7:0]      accel_x_r, accel_x_s, accel_y_r, accel_y_s;
   logic            valid_r, valid_s, init_done_r, init_done_s;

   // Next-state, datapath and next SPI pin values
   always_comb begin
      state_s     = state_r;
      wait_cnt_s  = wait_cnt_r;
      div_s       = div_r;
      step_s      = step_r;
      rx_s        = rx_r;
      accel_x_s   = accel_x_r;
      accel_y_s   = accel_y_r;
      valid_s     = 1'b0;
      init_done_s = init_done_r;
      half_done_s = (div_r == DIV_MAX);

      case (state_r)
         ST_CFG0: begin
            last_step_s = CFG0_LAST;
            after_s     = ST_CFG1;
         end
         ST_CFG1: begin
            last_step_s = CFG_BITS_END;
            after_s     = ST_WAIT;
         end
         default: begin
            last_step_s = READ_BITS_END;
            after_s     = ST_UPDATE;
         end
      endcase

      case (state_r)
         ST_PWRUP, ST_WAIT: begin
            if (wait_cnt_r == WAIT_MAX) begin
               wait_cnt_s = {WW{1'b0}};
               div_s      = {DW{1'b0}};
               step_s     = 7'd0;
               if (state_r == ST_PWRUP) begin
                  state_s = ST_CFG0;
               end else begin
                  state_s = ST_READ;
               end
            end else begin
               wait_cnt_s = wait_cnt_r + 1'b1;
            end
         end
         ST_CFG0, ST_CFG1, ST_READ: begin
            if (half_done_s) begin
               div_s = {DW{1'b0}};
               // Leaving an SCLK-low step means a rising edge: capture MISO.
               if ((state_r == ST_READ) && step_r[0]) begin
                  rx_s = {rx_r[30:0], miso_r};
               end else begin
                  rx_s = rx_r;
               end
               if (step_r == last_step_s) begin
                  step_s  = 7'd0;
                  state_s = after_s;
                  if (state_r == ST_CFG1) begin
                     init_done_s = 1'b1;
                  end else begin
                     init_done_s = init_done_r;
                  end
               end else begin
                  step_s = step_r + 1'b1;
               end
            end else begin
               div_s = div_r + 1'b1;
            end
         end
         ST_UPDATE: begin
            accel_x_s = apply_deadzone(saturate({rx_r[23:16], rx_r[31:24]}));
            accel_y_s = apply_deadzone(saturate({rx_r[7:0], rx_r[15:8]}));
            valid_s   = 1'b1;
            state_s   = ST_WAIT;
         end
         default: begin
            state_s = ST_PWRUP;
         end
      endcase

      xfer_s = (state_s == ST_CFG0) || (state_s == ST_CFG1) || (state_s == ST_READ);
      if (state_s == ST_READ) begin
         bit_last_s = READ_BITS_END;
      end else begin
         bit_last_s = CFG_BITS_END;
      end
      cs_low_s = xfer_s && (step_s <= bit_last_s);

      case (state_s)
         ST_CFG0: tx_word_s = {16'h3100, 24'h000000};
         ST_CFG1: tx_word_s = {16'h2D08, 24'h000000};
         ST_READ: tx_word_s = 40'hF2_0000_0000;
         default: tx_word_s = 40'h00_0000_0000;
      endcase
      bit_idx_s = 6'd39 - step_s[6:1];

      cs_n_s = ~cs_low_s;
      if (cs_low_s) begin
         sclk_s = ~step_s[0];
         if (step_s[0]) begin
            mosi_s = tx_word_s[bit_idx_s];
         end else begin
            mosi_s = mosi_r;
         end
      end else begin
         sclk_s = 1'b1;
         mosi_s = mosi_r;
      end
   end

   // State, counters, SPI pins and result registers
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         state_r     <= ST_PWRUP;
         wait_cnt_r  <= {WW{1'b0}};
         div_r       <= {DW{1'b0}};
         step_r      <= 7'd0;
         rx_r        <= 32'h0000_0000;
         miso_r      <= 1'b0;
         sclk_r      <= 1'b1;
         cs_n_r      <= 1'b1;
         mosi_r      <= 1'b0;
         accel_x_r   <= 8'h00;
         accel_y_r   <= 8'h00;
         valid_r     <= 1'b0;
         init_done_r <= 1'b0;
      end else begin
         state_r     <= state_s;
         wait_cnt_r  <= wait_cnt_s;
         div_r       <= div_s;
         step_r      <= step_s;
         rx_r        <= rx_s;
         miso_r      <= i_spi_miso;
         sclk_r      <= sclk_s;
         cs_n_r      <= cs_n_s;
         mosi_r      <= mosi_s;
         accel_x_r   <= accel_x_s;
         accel_y_r   <= accel_y_s;
         valid_r     <= valid_s;
         init_done_r <= init_done_s;
      end
   end

   assign o_spi_sclk  = sclk_r;
   assign o_spi_cs_n  = cs_n_r;
   assign o_spi_mosi  = mosi_r;
   assign o_accel_x   = accel_x_r;
   assign o_accel_y   = accel_y_r;
   assign o_valid     = valid_r;
   assign o_init_done = init_done_r;

endmodule

// File: tb/tb_accel_spi_reader.sv
// Bench for accel_spi_reader: an ADXL345-like SPI slave model plus a scoreboard of expected
// axis values; CS/SCLK framing and timing are recorded by a monitor and checked in order.
module tb_accel_spi_reader;

   localparam int CLK_DIV       = 3;
   localparam int SAMPLE_PERIOD = 60;
   localparam int SHIFT         = 2;
   localparam int DEADZONE      = 2;
   localparam int CFG_LEN       = CLK_DIV * (2 * 16 + 1);
   localparam int READ_LEN      = CLK_DIV * (2 * 40 + 1);
   localparam int PERIOD        = SAMPLE_PERIOD + READ_LEN + 1;
`ifdef ACCEL_DEADZONE_EN
   localparam logic [7:0] DZ_X = 8'h00;
   localparam logic [7:0] DZ_Y = 8'h00;
`else
   localparam logic [7:0] DZ_X = 8'h01;
   localparam logic [7:0] DZ_Y = 8'hFF;
`endif

   logic       clk = 1'b0;
   logic       arst_n = 1'b0;
   logic       i_spi_miso = 1'b1;
   logic       o_spi_sclk, o_spi_cs_n, o_spi_mosi, o_valid, o_init_done;
   logic [7:0] o_accel_x, o_accel_y;

   accel_spi_reader #(
      .CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(SAMPLE_PERIOD), .SHIFT(SHIFT), .DEADZONE(DEADZONE)
   ) dut (
      .clk(clk), .arst_n(arst_n),
      .o_spi_sclk(o_spi_sclk), .o_spi_cs_n(o_spi_cs_n), .o_spi_mosi(o_spi_mosi),
      .i_spi_miso(i_spi_miso),
      .o_accel_x(o_accel_x), .o_accel_y(o_accel_y),
      .o_valid(o_valid), .o_init_done(o_init_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [39:0] data;
      int          bits;
      int          len;
      int          gap;
      int          end_cyc;
      bit          hp_ok;
      logic        init;
   } frame_t;

   typedef struct packed {
      logic [7:0] x;
      logic [7:0] y;
   } exp_t;

   int vectors = 0;
   int miscompares = 0;

   frame_t      fb [64];
   int          fr_wr = 0;
   int          fr_rd = 0;
   int          vb_cyc [64];
   logic [7:0]  vb_x [64];
   logic [7:0]  vb_y [64];
   int          vw = 0;
   int          vr = 0;
   exp_t        exp_q [$];
   logic [39:0] miso_frame = 40'h0;

   int          cyc = 0;
   int          cur_bits = 0, cur_start = 0, cur_gap = 0, last_edge = 0, last_rise = 0, mbit = 0;
   bit          cur_hp = 1'b1;
   logic [39:0] cur_data = 40'h0;
   logic        prev_cs = 1'b1, prev_sclk = 1'b1, prev_rst = 1'b0;
   logic [7:0]  prev_x = 8'h00, prev_y = 8'h00;
   bit          idle_bad = 1'b0, chg_bad = 1'b0, early_valid = 1'b0;

   // SPI slave model and bus monitor, sampled on the inactive clock edge
   always @(negedge clk) begin
      cyc++;
      if (prev_cs === 1'b1 && o_spi_cs_n === 1'b0) begin
         cur_bits  = 0;
         cur_data  = 40'h0;
         cur_start = cyc;
         cur_gap   = cyc - last_rise;
         last_edge = cyc;
         mbit      = 0;
         cur_hp    = 1'b1;
      end else if (o_spi_cs_n === 1'b0 && o_spi_sclk !== prev_sclk) begin
         if (cyc - last_edge != CLK_DIV) cur_hp = 1'b0;
         last_edge = cyc;
         if (o_spi_sclk === 1'b0) begin
            if (mbit < 40) i_spi_miso = miso_frame[39 - mbit];
            mbit++;
         end else begin
            cur_data = {cur_data[38:0], o_spi_mosi};
            cur_bits++;
         end
      end else if (prev_cs === 1'b0 && o_spi_cs_n === 1'b1) begin
         if (cyc - last_edge != CLK_DIV) cur_hp = 1'b0;
         if (fr_wr < 64) begin
            fb[fr_wr].data    = cur_data;
            fb[fr_wr].bits    = cur_bits;
            fb[fr_wr].len     = cyc - cur_start;
            fb[fr_wr].gap     = cur_gap;
            fb[fr_wr].end_cyc = cyc;
            fb[fr_wr].hp_ok   = cur_hp;
            fb[fr_wr].init    = o_init_done;
         end
         fr_wr++;
         last_rise = cyc;
      end
      if (o_spi_cs_n === 1'b1 && o_spi_sclk === 1'b0) idle_bad = 1'b1;
      if (o_valid === 1'b1) begin
         if (o_init_done !== 1'b1) early_valid = 1'b1;
         if (vw < 64) begin
            vb_cyc[vw] = cyc;
            vb_x[vw]   = o_accel_x;
            vb_y[vw]   = o_accel_y;
         end
         vw++;
      end else if (prev_rst === 1'b1 && arst_n === 1'b1 &&
                   (o_accel_x !== prev_x || o_accel_y !== prev_y)) begin
         chg_bad = 1'b1;
      end
      prev_cs   = o_spi_cs_n;
      prev_sclk = o_spi_sclk;
      prev_rst  = arst_n;
      prev_x    = o_accel_x;
      prev_y    = o_accel_y;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
      end
   endtask

   task automatic wait_frames(input int n, input string tag);
      int b = 0;
      while ((fr_wr - fr_rd) < n && b < 3000) begin
         @(posedge clk);
         b++;
      end
      chk(tag, ((fr_wr - fr_rd) >= n) ? 64'd1 : 64'd0, 64'd1);
   endtask

   task automatic wait_valid(input string tag);
      int b = 0;
      while ((vw - vr) < 1 && b < 3000) begin
         @(posedge clk);
         b++;
      end
      chk(tag, ((vw - vr) >= 1) ? 64'd1 : 64'd0, 64'd1);
   endtask

   task automatic check_frame(input string tag, input int idx, input logic [39:0] data,
                              input int bits, input int len, input logic init);
      chk({tag, "_mosi"}, fb[idx].data, data);
      chk({tag, "_bits"}, fb[idx].bits, bits);
      chk({tag, "_cs_low_len"}, fb[idx].len, len);
      chk({tag, "_half_period"}, fb[idx].hp_ok, 1);
      chk({tag, "_init_done"}, fb[idx].init, init);
   endtask

   task automatic check_init_sequence(input string tag);
      wait_frames(3, {tag, "_frames_seen"});
      check_frame({tag, "_cfg0"}, fr_rd, 40'h3100, 16, CFG_LEN, 1'b0);
      check_frame({tag, "_cfg1"}, fr_rd + 1, 40'h2D08, 16, CFG_LEN, 1'b1);
      chk({tag, "_cfg_gap_ok"}, (fb[fr_rd + 1].gap >= 2 * CLK_DIV) ? 64'd1 : 64'd0, 64'd1);
      chk({tag, "_read_cmd"}, fb[fr_rd + 2].data[39:32], 8'hF2);
      fr_rd = fr_rd + 3;
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      wait_valid({tag, "_valid_seen"});
      e = exp_q.pop_front();
      chk({tag, "_x"}, vb_x[vr], e.x);
      chk({tag, "_y"}, vb_y[vr], e.y);
      chk({tag, "_latency"}, vb_cyc[vr] - fb[fr_wr - 1].end_cyc, 1);
      check_frame({tag, "_read"}, fr_wr - 1, 40'hF2_0000_0000, 40, READ_LEN, 1'b1);
      fr_rd = fr_wr;
   endtask

   logic [39:0] rd_miso [6];
   exp_t        rd_exp [6];

   initial begin
      exp_t e;
      int   b;
      rd_miso[0] = 40'h00_40_00_C0_FF;  rd_exp[0] = {8'h10, 8'hF0};
      rd_miso[1] = 40'h00_00_02_00_FE;  rd_exp[1] = {8'h7F, 8'h80};
      rd_miso[2] = 40'h00_FF_7F_00_80;  rd_exp[2] = {8'h7F, 8'h80};
      rd_miso[3] = 40'h00_04_00_FC_FF;  rd_exp[3] = {DZ_X, DZ_Y};
      rd_miso[4] = 40'h00_FC_01_FC_FD;  rd_exp[4] = {8'h7F, 8'h80};
      rd_miso[5] = 40'h00_2C_01_D4_FE;  rd_exp[5] = {8'h4B, 8'hB5};

      arst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", o_spi_cs_n, 1);
      chk("rst_sclk", o_spi_sclk, 1);
      chk("rst_mosi", o_spi_mosi, 0);
      chk("rst_x", o_accel_x, 0);
      chk("rst_y", o_accel_y, 0);
      chk("rst_valid", o_valid, 0);
      chk("rst_init_done", o_init_done, 0);

      miso_frame = rd_miso[0];
      exp_q.push_back(rd_exp[0]);
      @(negedge clk);
      #2 arst_n = 1'b1;

      check_init_sequence("init");
      for (int i = 0; i < 6; i++) begin
         check_result($sformatf("read%0d", i));
         if (i > 0) chk($sformatf("period%0d", i), vb_cyc[vr] - vb_cyc[vr - 1], PERIOD);
         vr++;
         if (i < 5) begin
            miso_frame = rd_miso[i + 1];
            exp_q.push_back(rd_exp[i + 1]);
         end
      end

      b = 0;
      while (!(o_spi_cs_n === 1'b0 && cur_bits >= 17 && cur_bits < 24) && b < 1000) begin
         @(posedge clk);
         b++;
      end
      chk("midread_reached", (b < 1000) ? 64'd1 : 64'd0, 64'd1);
      #1 arst_n = 1'b0;
      #1;
      chk("midrst_cs_n", o_spi_cs_n, 1);
      chk("midrst_sclk", o_spi_sclk, 1);
      chk("midrst_mosi", o_spi_mosi, 0);
      chk("midrst_x", o_accel_x, 0);
      chk("midrst_y", o_accel_y, 0);
      chk("midrst_init_done", o_init_done, 0);
      repeat (5) @(posedge clk);
      fr_rd = fr_wr;
      vr    = vw;
      miso_frame = 40'h00_00_01_00_FF;
      e.x = 8'h40;
      e.y = 8'hC0;
      exp_q.push_back(e);
      @(negedge clk);
      #2 arst_n = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rerun_init_low", o_init_done, 0);

      check_init_sequence("rerun");
      check_result("rerun");
      vr++;

      chk("sclk_idle_high", idle_bad, 0);
      chk("outputs_stable", chg_bad, 0);
      chk("valid_after_init", early_valid, 0);
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/accel_spi_reader.md
Name: accel_spi_reader

Overview:
Upstream stage of the ball positioner. Configures the on-board ADXL345 accelerometer over 4-wire SPI, then periodically burst-reads the X/Y data registers. Scales and saturates each axis to 8-bit two's complement, and holds the result on o_accel_x/o_accel_y, which feed the positioner's i_accel_x/i_accel_y directly.

Parameters:
CLK_DIV, 25, clk cycles per SCLK half-period (SCLK = clk/(2*CLK_DIV)); minimum 2
SAMPLE_PERIOD, 500000, clk cycles spent in WAIT before each read (also power-up delay before init)
SHIFT, 2, arithmetic right shift applied to 16-bit raw axis value before saturation (0..8)
DEADZONE, 2, magnitude threshold used only when ACCEL_DEADZONE_EN is defined

Ports:
clk  in  1  system clock
arst_n  in  1  asynchronous reset, active-low
o_spi_sclk  out  1  SPI clock, mode 3 (idle high)
o_spi_cs_n  out  1  chip select, active-low
o_spi_mosi  out  1  master data out, MSB first
i_spi_miso  in  1  slave data in
o_accel_x  out  8  signed X acceleration, scaled/saturated
o_accel_y  out  8  signed Y acceleration, scaled/saturated
o_valid  out  1  one-cycle pulse when o_accel_x/y update
o_init_done  out  1  high once both config writes are complete; stays high until reset

Behaviour:
- Reset (async, arst_n=0): cs_n=1, sclk=1, mosi=0, o_accel_x=o_accel_y=0, o_valid=0, o_init_done=0, state=PWRUP, all counters 0. Mid-transaction reset aborts immediately; no partial update of outputs.
- Clocking: single clk domain. SCLK, CS_n and MOSI are registered outputs. MISO is registered once before use.
- Transaction framing:
  - cs_n falls; after CLK_DIV cycles, first SCLK falling edge; MOSI changes on falling edges.
  - MISO is sampled on rising edges; each SCLK level lasts CLK_DIV cycles.
  - After the last rising edge, wait CLK_DIV cycles, then raise cs_n; cs_n stays high at least 2*CLK_DIV cycles before the next transaction.
- State machine:
  - PWRUP: count SAMPLE_PERIOD cycles -> CFG0.
  - CFG0: 2-byte write, MOSI = 0x31, 0x00 (DATA_FORMAT: +-2g, 10-bit right-justified, 4-wire) -> CFG1.
  - CFG1: 2-byte write, MOSI = 0x2D, 0x08 (POWER_CTL: measure); at cs_n rise set o_init_done=1 -> WAIT.
  - WAIT: count SAMPLE_PERIOD cycles -> READ.
  - READ: 5-byte transaction. Byte 0 MOSI = 0xF2 (R=1, MB=1, addr 0x32); bytes 1..4 MOSI = 0x00 while capturing DATAX0, DATAX1, DATAY0, DATAY1 -> UPDATE.
  - UPDATE: one cycle, then -> WAIT.
- Arithmetic in UPDATE:
  - raw_x = {DATAX1,DATAX0}, raw_y = {DATAY1,DATAY0}, both 16-bit signed.
  - s = raw >>> SHIFT, kept at 16 bits signed.
  - Saturate: s>127 -> 127 (0x7F); s<-128 -> -128 (0x80); otherwise s[7:0].
  - Outputs register the result; o_valid=1 for exactly that cycle.
- Outputs hold their last value between updates. o_valid is never asserted before o_init_done.
- Output latency: o_valid asserts on the cycle after cs_n rises at the end of READ.
- Counter widths are sized with $clog2 of the parameters; no wrap-around within a count.

Optional Feature:
ACCEL_DEADZONE_EN
- Defined: after saturation, any axis value with |v| < DEADZONE is forced to 0 before registering, so a resting board keeps the ball still.
- Not defined: saturated value is registered unchanged; the DEADZONE parameter is ignored.

Test Plan:
- Init sequence with SPI slave model: after reset and SAMPLE_PERIOD, MOSI bytes are 0x31,0x00 | 0x2D,0x08 in separate cs_n frames. o_init_done rises after the second frame. First READ command byte is 0xF2. Check SCLK idle high and half-period = CLK_DIV.
- Nominal read: MISO returns 0x40,0x00,0xC0,0xFF (X=+64, Y=-64) -> o_accel_x=0x10, o_accel_y=0xF0 with a single o_valid pulse.
- Saturation: MISO returns 0x00,0x02,0x00,0xFE (X=+512, Y=-512) -> o_accel_x=0x7F, o_accel_y=0x80. Repeat with 0xFF,0x7F,0x00,0x80 -> 0x7F, 0x80.
- Deadzone: X raw 0x0004, Y raw 0xFFFC -> with ACCEL_DEADZONE_EN: 0x00/0x00; without: 0x01/0xFF.
- Periodicity: o_valid pulses spaced exactly SAMPLE_PERIOD + READ frame length + 1 cycles; outputs stable between pulses.
- Reset mid-READ: assert arst_n=0 during byte 2 -> cs_n=1, sclk=1, outputs 0, o_init_done=0 immediately. After release, the full PWRUP/CFG0/CFG1 sequence repeats.
